// File: rtl/spine_router_rr.sv
// spine_router_rr: NP-port spine router; clk/reset, in_data/in_valid/in_ready per-input FIFOs, header routing, per-output round-robin into out_data/out_valid/out_ready registers, saturating drop_count
module spine_router_rr #(
  parameter int GROUP_ID   = 2,
  parameter int GID_W      = 4,
  parameter int LID_W      = 2,
  parameter int NUM_LEAF   = 4,
  parameter int NUM_GROUP  = 7,
  parameter int DWIDTH     = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int NP = NUM_LEAF + NUM_GROUP
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NP*DWIDTH-1:0] in_data,
  input  logic [NP-1:0]        in_valid,
  output logic [NP-1:0]        in_ready,
  output logic [NP*DWIDTH-1:0] out_data,
  output logic [NP-1:0]        out_valid,
  input  logic [NP-1:0]        out_ready,
  output logic [7:0]           drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(NP);
  logic [DWIDTH-1:0] mem_q [NP][FIFO_DEPTH];
  logic [DWIDTH-1:0] mem_d [NP][FIFO_DEPTH];
  logic [AW:0]       wp_q [NP], wp_d [NP], rp_q [NP], rp_d [NP];
  logic [PW-1:0]     rr_q [NP], rr_d [NP];
  logic [DWIDTH-1:0] od_q [NP], od_d [NP];
  logic [NP-1:0]     ov_q, ov_d;
  logic [7:0]        dc_q, dc_d;
  logic [DWIDTH-1:0] head [NP];
  logic [PW-1:0]     tgt [NP], gi [NP];
  logic [NP-1:0]     full, ok, drop, load, gv, pop;
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      int dg, dl, t;
      head[i] = mem_q[i][rp_q[i][AW-1:0]];
      dg = int'(head[i][DWIDTH-1 -: GID_W]);
      dl = int'(head[i][DWIDTH-GID_W-1 -: LID_W]);
      t = dg == GROUP_ID ? dl : dg < GROUP_ID ? NUM_LEAF + dg : NUM_LEAF + dg - 1;
      full[i] = wp_q[i] == {~rp_q[i][AW], rp_q[i][AW-1:0]};
      in_ready[i] = !full[i] && !reset;
      ok[i] = wp_q[i] != rp_q[i] && (dg == GROUP_ID ? dl < NUM_LEAF : t < NP);
      drop[i] = wp_q[i] != rp_q[i] && !ok[i];
      tgt[i] = PW'(t);
    end
  end
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      logic f;
      logic [PW-1:0] g;
      f = 1'b0;
      g = '0;
      for (int k = 0; k < NP; k++) begin
        int idx;
        idx = (int'(rr_q[o]) + k) % NP;
        if (!f && ok[idx] && tgt[idx] == PW'(o)) begin
          f = 1'b1;
          g = PW'(idx);
        end
      end
      load[o] = !ov_q[o] || out_ready[o];
      gv[o] = f;
      gi[o] = g;
    end
  end
  always_comb begin
    pop = drop;
    for (int o = 0; o < NP; o++)
      if (load[o] && gv[o]) pop[gi[o]] = 1'b1;
  end
  always_comb begin
    mem_d = mem_q;
    wp_d = wp_q;
    rp_d = rp_q;
    rr_d = rr_q;
    od_d = od_q;
    ov_d = ov_q;
    dc_d = int'(dc_q) + $countones(drop) > 255 ? 8'hff : dc_q + 8'($countones(drop));
    for (int i = 0; i < NP; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        mem_d[i][wp_q[i][AW-1:0]] = in_data[i*DWIDTH +: DWIDTH];
        wp_d[i] = wp_q[i] + 1'b1;
      end
      if (pop[i]) rp_d[i] = rp_q[i] + 1'b1;
    end
    for (int o = 0; o < NP; o++)
      if (load[o]) begin
        ov_d[o] = gv[o];
        if (gv[o]) begin
          od_d[o] = head[gi[o]];
          rr_d[o] = int'(gi[o]) == NP - 1 ? '0 : gi[o] + 1'b1;
        end
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wp_q <= '{default: '0};
      rp_q <= '{default: '0};
      rr_q <= '{default: '0};
      od_q <= '{default: '0};
      ov_q <= '0;
      dc_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      rr_q <= rr_d;
      od_q <= od_d;
      ov_q <= ov_d;
      dc_q <= dc_d;
    end
  end
  always_comb begin
    out_data = '0;
    for (int o = 0; o < NP; o++) out_data[o*DWIDTH +: DWIDTH] = od_q[o];
  end
  assign out_valid = ov_q;
  assign drop_count = dc_q;
endmodule

// File: doc/spine_router_rr.md
# spine_router_rr

Parametrised next-generation spine router for the group/leaf fabric. It provides NUM_LEAF leaf-facing ports and NUM_GROUP inter-group ports on one flattened port vector, with full valid/ready backpressure. Each input has its own FIFO, every flit is routed by header, and each output has its own round-robin arbiter and output register. Flits whose destination is unroutable are dropped and counted. The block replaces fixed-width, fixed-port spine routers in every group.

## Interface
- GROUP_ID, 2: this router's group number.
- GID_W, 4: width of the destination-group header field.
- LID_W, 2: width of the destination-leaf header field.
- NUM_LEAF, 4: number of leaf ports, indices 0..NUM_LEAF-1.
- NUM_GROUP, 7: number of group ports, indices NUM_LEAF..NP-1.
- DWIDTH, 16: flit width; must be ≥ GID_W+LID_W.
- FIFO_DEPTH, 8: entries per input FIFO; power of two, ≥2.
- NP (derived): NUM_LEAF+NUM_GROUP.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  NP*DWIDTH  input flits; port p occupies bits [p*DWIDTH +: DWIDTH].
- in_valid  in  NP  input flit valid, per port.
- in_ready  out  NP  input accept, per port.
- out_data  out  NP*DWIDTH  output flits, same packing as in_data.
- out_valid  out  NP  output flit valid, per port.
- out_ready  in  NP  downstream accept, per port.
- drop_count  out  8  saturating count of dropped flits.

## Operation
- Header fields: dg = flit[DWIDTH-1 -: GID_W], dl = flit[DWIDTH-GID_W-1 -: LID_W]. Every flit is single-word and self-routed.
- Route calculation, applied to the FIFO head flit:
  - dg==GROUP_ID: target = dl. If dl ≥ NUM_LEAF the flit is invalid.
  - dg<GROUP_ID: target = NUM_LEAF+dg.
  - dg>GROUP_ID: target = NUM_LEAF+dg-1.
  - A group target ≥ NP is invalid.
- Invalid head flit: popped in the cycle it reaches the head; it requests no output and drop_count increments. drop_count saturates at 255.
- Input side, per port: FIFO write when in_valid&in_ready. in_ready = !fifo_full & !reset.
- Arbitration, per output o:
  - Requesters are all non-empty FIFOs whose head targets o.
  - Round-robin: the search starts at rr_ptr[o]. On a grant to input i, rr_ptr[o] ← (i+1) mod NP.
  - rr_ptr resets to 0.
  - U-turn (target == own input port) is legal.
- Output stage, per port: a one-entry register. It loads when (!out_valid | out_ready) and a grant exists. The granted FIFO pops in that same cycle.
- One input feeds at most one output per cycle, because each flit has a single target. Distinct outputs grant in parallel with no interaction.
- The output register holds out_data stable while out_valid & !out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=0 while reset is high, all FIFOs empty, rr_ptr=0, drop_count=0.
- A reset asserted mid-operation discards all buffered and in-flight flits the next edge.
- Latency with no contention: flit accepted at edge 0, arbitrated in cycle 1, out_valid high after edge 1. That is 2 cycles from input handshake to output valid.
- Throughput: 1 flit/cycle/output under continuous out_ready. A held output lets its FIFOs fill; in_ready falls the cycle a FIFO holds FIFO_DEPTH entries.
- Full FIFO with a pop in the same cycle: no write that cycle, because in_ready was already 0. in_ready rises the next cycle.
- Empty FIFO: a write at edge n is visible at the head in cycle n+1. There is no bypass path.
- FIFO pointers wrap mod FIFO_DEPTH and use an extra MSB for full/empty detection.

## Test plan
- Single flit: port 0 sends 0x2400 (dg=2, dl=1) → out_valid[1] rises 2 cycles later with data 0x2400; no other outputs toggle.
- Inter-group routing: port 1 sends dg=5 → arrives on port NUM_LEAF+4=8. Port 1 sends dg=0 → arrives on port 4.
- Contention: ports 0, 2, 5 each send 4 flits to leaf 3, out_ready=1 → grant order is 0,2,5 repeating. Each input receives exactly 4 grants in 12 consecutive cycles.
- Backpressure: out_ready[1]=0 while port 0 streams to leaf 1 → 1 flit held in the output register plus 8 in the FIFO, then in_ready[0]=0. Releasing out_ready delivers all 9 flits in order with no loss.
- Drops: send dg=2, dl=3 with NUM_LEAF=3, then dg=15 → drop_count=2 and nothing is output. 300 bad flits → drop_count=255.
- Reset mid-stream: assert reset with FIFOs half full → the next cycle all out_valid=0 and drop_count=0. After release, the first new flit arrives with 2-cycle latency.
